// File: rtl/hack_data_memory.sv
// Hack data-memory subsystem: RAM, screen buffer, keyboard register and a write-only UART
// transmitter behind a single CPU port, plus a read-only scanner port into the screen.
module hack_data_memory #(
    parameter int          CLKS_PER_BIT = 25,
    parameter logic [15:0] UART_ADDR    = 16'h6001
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] address,
    input  logic [15:0] data_in,
    input  logic        load,
    output logic [15:0] out,
    input  logic [15:0] key,
    input  logic [12:0] screen_addr,
    output logic [15:0] screen_data,
    output logic        tx
);
    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    logic [15:0]   ram_q [0:16383];
    logic [15:0]   scr_q [0:8191];
    logic [15:0]   kbd_q;
    uart_state_e   state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    bit_q;
    logic [7:0]    byte_q;
    logic          tx_q;

    logic sel_ram, sel_scr, sel_kbd, sel_uart;
    logic wr_en, busy, uart_wr;
    logic [2:0] bit_nxt;

    // Full 16-bit decode: anything outside these windows reads 0 and ignores writes.
    assign sel_ram  = (address[15:14] == 2'b00);
    assign sel_scr  = (address[15:13] == 3'b010);
    assign sel_kbd  = (address == 16'h6000);
    assign sel_uart = (address == UART_ADDR);

    // Reset wins over a same-cycle write to any target.
    assign wr_en   = load && !reset;
    assign busy    = (state_q != ST_IDLE);
    assign uart_wr = load && sel_uart && !busy;
    assign bit_nxt = bit_q + 3'd1;

    always_ff @(posedge clk) begin
        if (wr_en && sel_ram) ram_q[address[13:0]] <= data_in;
        if (wr_en && sel_scr) scr_q[address[12:0]] <= data_in;
    end

    always_ff @(posedge clk) begin
        if (reset) kbd_q <= 16'h0000;
        else       kbd_q <= key;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            byte_q  <= 8'h00;
            tx_q    <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (uart_wr) begin
                        byte_q  <= data_in[7:0];
                        tx_q    <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= ST_START;
                    end
                end
                ST_START: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q   <= '0;
                        bit_q   <= 3'd0;
                        tx_q    <= byte_q[0];
                        state_q <= ST_DATA;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q <= '0;
                        if (bit_q == 3'd7) begin
                            tx_q    <= 1'b1;
                            state_q <= ST_STOP;
                        end else begin
                            bit_q <= bit_nxt;
                            tx_q  <= byte_q[bit_nxt];
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q   <= '0;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        out = 16'h0000;
        if (sel_ram)       out = ram_q[address[13:0]];
        else if (sel_scr)  out = scr_q[address[12:0]];
        else if (sel_kbd)  out = kbd_q;
        else if (sel_uart) out = {15'b0, busy};
    end

    assign screen_data = scr_q[screen_addr];
    assign tx          = tx_q;

endmodule
